// File: rtl/spi_pkg.sv
// Shared definitions for the configurable SPI master: mode encodings and FSM states.
package spi_pkg;

    // Mode encoding is {cpol, cpha}.
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        TRAIL = 2'd2
    } state_e;

endpackage

// File: rtl/spi_clkgen.sv
// SCK generator: half-period down-counter, SCK toggle register and lead/trail edge strobes.
module spi_clkgen #(
    parameter int DIVW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic [DIVW-1:0] divider,
    input  logic            cpol,
    output logic            sck,
    output logic            lead,
    output logic            trail
);

    logic [DIVW-1:0] cnt_q, cnt_d;
    logic            sck_q, sck_d;
    logic            tick;

    // An SCK edge is produced at the clk edge where the counter has reached zero.
    assign tick  = run && (cnt_q == '0);
    assign lead  = tick && (sck_q == cpol);
    assign trail = tick && (sck_q != cpol);
    assign sck   = sck_q;

    always_comb begin
        cnt_d = cnt_q;
        sck_d = sck_q;
        if (!run) begin
            cnt_d = divider;
            sck_d = cpol;
        end else if (tick) begin
            cnt_d = divider;
            sck_d = ~sck_q;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

endmodule

// File: rtl/spi_master_cfg.sv
// Configurable SPI master: 1..MAXBITS bit transfers, programmable SCK divider, CPOL/CPHA modes.
// Handshake: wr is taken only on a clk edge where busy=0; wr while busy is dropped, done pulses once at the end.
module spi_master_cfg
    import spi_pkg::*;
#(
    parameter int MAXBITS = 32,
    parameter int LENW    = $clog2(MAXBITS),
    parameter int DIVW    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr,
    input  logic [MAXBITS-1:0] din,
    input  logic [LENW-1:0]    bits,
    input  logic [DIVW-1:0]    divider,
    input  logic               cpol,
    input  logic               cpha,
    input  logic               miso,
    output logic               sck,
    output logic               mosi,
    output logic               busy,
    output logic               done,
    output logic [MAXBITS-1:0] dout
);

    localparam logic [LENW-1:0] TOP_IDX = LENW'(MAXBITS - 1);

    state_e             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [DIVW-1:0]    div_q, div_d;
    logic [LENW-1:0]    bits_q, bits_d;
    logic [LENW:0]      bit_cnt_q, bit_cnt_d;
    logic [MAXBITS-1:0] tx_q, tx_d;
    logic [MAXBITS-1:0] rx_q, rx_d;
    logic [MAXBITS-1:0] dout_q, dout_d;
    logic               mosi_q, mosi_d;
    logic               done_q, done_d;

    logic               run, lead, trail, last_bit;
    logic               sample_lead, sample_ev, shift_ev;
    logic               clk_cpol;
    logic [DIVW-1:0]    clk_div;
    logic [MAXBITS-1:0] din_aligned;

    assign run      = (state_q != IDLE);
    assign last_bit = (bit_cnt_q == {1'b0, bits_q});

    // Left-align the active bits so the first bit out is always the MSB of the shifter.
    assign din_aligned = din << (TOP_IDX - bits);

    // Config is muxed so the clock generator starts from the new cpol/divider on the accepting edge.
    assign clk_cpol = (!run && wr) ? cpol : mode_q[1];
    assign clk_div  = run ? div_q : divider;

    assign sample_lead = (mode_q == MODE0) || (mode_q == MODE2);
    assign sample_ev   = sample_lead ? lead : trail;
    assign shift_ev    = sample_lead ? (trail && !last_bit) : lead;

    spi_clkgen #(
        .DIVW (DIVW)
    ) u_clkgen (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .divider (clk_div),
        .cpol    (clk_cpol),
        .sck     (sck),
        .lead    (lead),
        .trail   (trail)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        div_d     = div_q;
        bits_d    = bits_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        dout_d    = dout_q;
        mosi_d    = mosi_q;
        done_d    = 1'b0;

        if (sample_ev) begin
            rx_d = {rx_q[MAXBITS-2:0], miso};
        end
        if (shift_ev) begin
            mosi_d = tx_q[MAXBITS-1];
            tx_d   = {tx_q[MAXBITS-2:0], 1'b0};
        end

        case (state_q)
            IDLE: begin
                if (wr) begin
                    state_d   = LEAD;
                    mode_d    = {cpol, cpha};
                    div_d     = divider;
                    bits_d    = bits;
                    bit_cnt_d = '0;
                    rx_d      = '0;
                    if (cpha) begin
                        tx_d = din_aligned;
                    end else begin
                        // CPHA=0 needs the first bit on the wire before the first leading edge.
                        mosi_d = din_aligned[MAXBITS-1];
                        tx_d   = {din_aligned[MAXBITS-2:0], 1'b0};
                    end
                end
            end
            LEAD: begin
                if (lead) begin
                    state_d = TRAIL;
                end
            end
            TRAIL: begin
                if (trail) begin
                    if (last_bit) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        dout_d  = rx_d;
                    end else begin
                        state_d   = LEAD;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mode_q    <= MODE0;
            div_q     <= '0;
            bits_q    <= '0;
            bit_cnt_q <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            dout_q    <= '0;
            mosi_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            div_q     <= div_d;
            bits_q    <= bits_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            dout_q    <= dout_d;
            mosi_q    <= mosi_d;
            done_q    <= done_d;
        end
    end

    assign busy = run;
    assign mosi = mosi_q;
    assign done = done_q;
    assign dout = dout_q;

endmodule
